// File: rtl/forward_ysyx_23060136_pkg.sv
// Shared types for the EXU operand-forwarding block.
//   forward_state_t : load-use FSM states.
//   forward_src_t   : per-operand source of the forwarded value.
//   XLEN            : datapath width.
package forward_ysyx_23060136_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } forward_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_WB   = 2'd2,
        SRC_CAP  = 2'd3
    } forward_src_t;

endpackage

// File: rtl/forward_match_ysyx_23060136.sv
// One-operand forwarding unit.
// Compares an EXU source address against the MEM and WB writers, picks the
// youngest match (MEM, WB, capture register), and keeps a capture register
// so a WB result retiring while EXU is stalled is still forwarded later.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   exu_valid/fire/flush             : EXU handshake
//   rs, used                         : operand address and read enable
//   mem_* / wb_*                     : writer status, address and data
//   fwd_data, fwd_hazard             : forwarded value and its select
//   load_pending                     : MEM load matches but data not back yet
module forward_match_ysyx_23060136
    import forward_ysyx_23060136_pkg::*;
#(
    parameter int AW        = 5,
    parameter bit ZERO_EXCL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exu_valid,
    input  logic            exu_fire,
    input  logic            exu_flush,
    input  logic [AW-1:0]   rs,
    input  logic            used,
    input  logic            mem_valid,
    input  logic            mem_wen,
    input  logic            mem_is_load,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] mem_load_data,
    input  logic            mem_load_done,
    input  logic            wb_valid,
    input  logic            wb_wen,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data,
    output logic            fwd_hazard,
    output logic            load_pending
);

    logic            addr_ok;
    logic            mem_hit;
    logic            wb_hit;
    forward_src_t    src;
    logic            cap_valid_q, cap_valid_d;
    logic [XLEN-1:0] cap_data_q,  cap_data_d;

    // x0 is hardwired to zero, so a write to it never forwards.
    assign addr_ok = ZERO_EXCL ? (rs != '0) : 1'b1;
    assign mem_hit = used & addr_ok & mem_valid & mem_wen & (mem_rd == rs);
    assign wb_hit  = used & addr_ok & wb_valid  & wb_wen  & (wb_rd  == rs);

    always_comb begin
        src = SRC_NONE;
        if (mem_hit)          src = SRC_MEM;
        else if (wb_hit)      src = SRC_WB;
        else if (cap_valid_q) src = SRC_CAP;
    end

    always_comb begin
        fwd_data     = '0;
        fwd_hazard   = 1'b0;
        load_pending = 1'b0;
        if (!rst) begin
            unique case (src)
                SRC_MEM: begin
                    if (mem_is_load) begin
                        // An outstanding load blocks older sources: forwarding
                        // WB or capture data here would hand EXU a stale value.
                        if (mem_load_done) begin
                            fwd_data   = mem_load_data;
                            fwd_hazard = 1'b1;
                        end else begin
                            load_pending = 1'b1;
                        end
                    end else begin
                        fwd_data   = mem_data;
                        fwd_hazard = 1'b1;
                    end
                end
                SRC_WB: begin
                    fwd_data   = wb_data;
                    fwd_hazard = 1'b1;
                end
                SRC_CAP: begin
                    fwd_data   = cap_data_q;
                    fwd_hazard = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cap_valid_d = cap_valid_q;
        cap_data_d  = cap_data_q;
        if (exu_fire || exu_flush) begin
            cap_valid_d = 1'b0;
        end else if (exu_valid && wb_hit) begin
            cap_valid_d = 1'b1;
            cap_data_d  = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_data_q  <= cap_data_d;
        end
    end

endmodule

// File: rtl/forward_ysyx_23060136.sv
// EXU operand-forwarding producer.
// Drives forwarded data/hazard pairs for rs1, rs2 and the CSR source, stalls
// EXU while a MEM load feeding a GPR operand is outstanding, and keeps a
// saturating count of stall cycles.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   EXU_*                          : EXU handshake, source addresses, use bits
//   MEM_*                          : MEM writer status/addresses/data, load return
//   WB_*                           : WB writer status/addresses/data
//   FORWARD_*_data_EXU / _hazard   : forwarded operands and selects
//   FORWARD_stall_EXU              : EXU must not fire this cycle
//   FORWARD_stall_cnt              : saturating stall-cycle counter
module forward_ysyx_23060136
    import forward_ysyx_23060136_pkg::*;
#(
    parameter int GPR_AW = 5,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EXU_valid,
    input  logic              EXU_fire,
    input  logic              EXU_flush,
    input  logic [GPR_AW-1:0] EXU_rs1,
    input  logic [GPR_AW-1:0] EXU_rs2,
    input  logic [CSR_AW-1:0] EXU_csr_rs,
    input  logic              EXU_rs1_used,
    input  logic              EXU_rs2_used,
    input  logic              EXU_csr_used,
    input  logic              MEM_valid,
    input  logic              MEM_write_gpr,
    input  logic              MEM_write_csr,
    input  logic              MEM_is_load,
    input  logic [GPR_AW-1:0] MEM_rd,
    input  logic [CSR_AW-1:0] MEM_csr_rd,
    input  logic [31:0]       MEM_rd_data,
    input  logic [31:0]       MEM_csr_rd_data,
    input  logic [31:0]       MEM_load_data,
    input  logic              MEM_load_done,
    input  logic              WB_valid,
    input  logic              WB_write_gpr,
    input  logic              WB_write_csr,
    input  logic [GPR_AW-1:0] WB_rd,
    input  logic [CSR_AW-1:0] WB_csr_rd,
    input  logic [31:0]       WB_rd_data,
    input  logic [31:0]       WB_csr_rd_data,
    output logic [31:0]       FORWARD_rs1_data_EXU,
    output logic [31:0]       FORWARD_rs2_data_EXU,
    output logic [31:0]       FORWARD_csr_rs_data_EXU,
    output logic              FORWARD_rs1_hazard_EXU,
    output logic              FORWARD_rs2_hazard_EXU,
    output logic              FORWARD_csr_rs_hazard_EXU,
    output logic              FORWARD_stall_EXU,
    output logic [31:0]       FORWARD_stall_cnt
);

    logic           rs1_pend, rs2_pend, csr_pend;
    logic           load_use;
    logic           stall;
    forward_state_t state_q, state_d;
    logic [31:0]    stall_cnt_q, stall_cnt_d;

    forward_match_ysyx_23060136 #(.AW(GPR_AW), .ZERO_EXCL(1'b1)) u_rs1 (
        .clk(clk), .rst(rst),
        .exu_valid(EXU_valid), .exu_fire(EXU_fire), .exu_flush(EXU_flush),
        .rs(EXU_rs1), .used(EXU_rs1_used),
        .mem_valid(MEM_valid), .mem_wen(MEM_write_gpr), .mem_is_load(MEM_is_load),
        .mem_rd(MEM_rd), .mem_data(MEM_rd_data),
        .mem_load_data(MEM_load_data), .mem_load_done(MEM_load_done),
        .wb_valid(WB_valid), .wb_wen(WB_write_gpr), .wb_rd(WB_rd), .wb_data(WB_rd_data),
        .fwd_data(FORWARD_rs1_data_EXU), .fwd_hazard(FORWARD_rs1_hazard_EXU),
        .load_pending(rs1_pend)
    );

    forward_match_ysyx_23060136 #(.AW(GPR_AW), .ZERO_EXCL(1'b1)) u_rs2 (
        .clk(clk), .rst(rst),
        .exu_valid(EXU_valid), .exu_fire(EXU_fire), .exu_flush(EXU_flush),
        .rs(EXU_rs2), .used(EXU_rs2_used),
        .mem_valid(MEM_valid), .mem_wen(MEM_write_gpr), .mem_is_load(MEM_is_load),
        .mem_rd(MEM_rd), .mem_data(MEM_rd_data),
        .mem_load_data(MEM_load_data), .mem_load_done(MEM_load_done),
        .wb_valid(WB_valid), .wb_wen(WB_write_gpr), .wb_rd(WB_rd), .wb_data(WB_rd_data),
        .fwd_data(FORWARD_rs2_data_EXU), .fwd_hazard(FORWARD_rs2_hazard_EXU),
        .load_pending(rs2_pend)
    );

    // CSR writes never come from a load, so this instance sees is_load tied
    // low and its load_pending output is structurally zero.
    forward_match_ysyx_23060136 #(.AW(CSR_AW), .ZERO_EXCL(1'b0)) u_csr (
        .clk(clk), .rst(rst),
        .exu_valid(EXU_valid), .exu_fire(EXU_fire), .exu_flush(EXU_flush),
        .rs(EXU_csr_rs), .used(EXU_csr_used),
        .mem_valid(MEM_valid), .mem_wen(MEM_write_csr), .mem_is_load(1'b0),
        .mem_rd(MEM_csr_rd), .mem_data(MEM_csr_rd_data),
        .mem_load_data(MEM_load_data), .mem_load_done(MEM_load_done),
        .wb_valid(WB_valid), .wb_wen(WB_write_csr), .wb_rd(WB_csr_rd), .wb_data(WB_csr_rd_data),
        .fwd_data(FORWARD_csr_rs_data_EXU), .fwd_hazard(FORWARD_csr_rs_hazard_EXU),
        .load_pending(csr_pend)
    );

    assign load_use = rs1_pend | rs2_pend | csr_pend;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_use) begin
                    state_d = LOAD_WAIT;
                    stall   = 1'b1;
                end
            end
            LOAD_WAIT: begin
                // Load data returning this cycle is forwarded directly by the
                // match units, so the stall drops in the same cycle.
                if (EXU_flush || MEM_load_done) state_d = IDLE;
                else                            stall   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (rst) stall = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign FORWARD_stall_EXU = stall;
    assign FORWARD_stall_cnt = stall_cnt_q;

endmodule
